// File: rtl/toeplitz_outbuf.sv
// toeplitz_outbuf: block FIFO plus LSB-first serializer behind the Toeplitz extractor.
// Blocks that find the FIFO full are dropped and counted; the extractor never stalls.
module toeplitz_outbuf #(
   parameter int L     = 128,
   parameter int OW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [L-1:0]               q,
   input  logic                       qstrobe,
   output logic [OW-1:0]              dout,
   output logic                       dvalid,
   input  logic                       dready,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       overflow,
   output logic [15:0]                drop_cnt
);
   localparam int NW = L / OW;
   localparam int LW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int IW = (NW > 1) ? $clog2(NW) : 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t        state;
   logic [L-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [L-1:0]  shreg;
   logic [IW-1:0] idx;
   logic          hs;
   logic          last;
   logic          pop;
   logic          push;
   logic          drop;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign hs   = dvalid && dready;
   assign last = (idx == IW'(NW - 1));
   // A full FIFO still accepts a block when its head leaves in the same cycle.
   assign pop  = (level != '0) && ((state == IDLE) || (hs && last));
   assign push = qstrobe && ((level != LW'(DEPTH)) || pop);
   assign drop = qstrobe && !push;
   assign dout = shreg[OW-1:0];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         dvalid   <= 1'b0;
         shreg    <= '0;
         idx      <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= nxt(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= nxt(rd_ptr);
         end
         if (push && !pop) begin
            level <= level + LW'(1);
         end else if (pop && !push) begin
            level <= level - LW'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) begin
               drop_cnt <= drop_cnt + 16'd1;
            end
         end
         unique case (state)
            IDLE: begin
               if (pop) begin
                  shreg  <= mem[rd_ptr];
                  idx    <= '0;
                  state  <= SHIFT;
                  dvalid <= 1'b1;
               end
            end
            SHIFT: begin
               if (hs) begin
                  if (!last) begin
                     shreg <= shreg >> OW;
                     idx   <= idx + IW'(1);
                  end else if (pop) begin
                     shreg <= mem[rd_ptr];
                     idx   <= '0;
                  end else begin
                     state  <= IDLE;
                     dvalid <= 1'b0;
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_toeplitz_outbuf.sv
// Bench for toeplitz_outbuf: vector table, directed corner cases and a
// randomized run checked every cycle against a queue-based reference model.
module tb_toeplitz_outbuf;
   localparam int L     = 128;
   localparam int OW    = 8;
   localparam int DEPTH = 4;
   localparam int NW    = L / OW;
   localparam int LW    = $clog2(DEPTH + 1);
   localparam logic [L-1:0] SINGLE = 128'h0F0E0D0C0B0A09080706050403020100;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [L-1:0]  q = '0;
   logic          qstrobe = 1'b0;
   logic [OW-1:0] dout;
   logic          dvalid;
   logic          dready = 1'b0;
   logic [LW-1:0] level;
   logic          overflow;
   logic [15:0]   drop_cnt;

   toeplitz_outbuf #(.L(L), .OW(OW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .q        (q),
      .qstrobe  (qstrobe),
      .dout     (dout),
      .dvalid   (dvalid),
      .dready   (dready),
      .level    (level),
      .overflow (overflow),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Reference model: queue of stored blocks plus the block being sent.
   logic [L-1:0] pend[$];
   logic [L-1:0] cur = '0;
   int           cur_rem = 0;
   bit           m_ovf = 1'b0;
   int           m_drop = 0;
   bit           m_live = 1'b0;
   bit           m_hs;
   bit           m_pop;
   bit           m_acc;

   always @(posedge clk) begin
      if (!reset_n) begin
         pend.delete();
         cur_rem = 0;
         m_ovf   = 1'b0;
         m_drop  = 0;
         m_live  = 1'b1;
      end else if (m_live) begin
         m_hs  = (cur_rem > 0) && dready;
         m_pop = (pend.size() > 0) && (cur_rem == 0 || (m_hs && cur_rem == 1));
         m_acc = qstrobe && (pend.size() < DEPTH || m_pop);
         if (qstrobe && !m_acc) begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
         end
         if (m_hs) cur_rem--;
         if (m_pop) begin
            cur     = pend.pop_front();
            cur_rem = NW;
         end
         if (m_acc) pend.push_back(q);
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("m_dvalid", int'(dvalid), int'(cur_rem > 0));
         if (cur_rem > 0)
            chk("m_dout", int'(dout), int'(cur[(NW-cur_rem)*OW +: OW]));
         chk("m_level", int'(level), pend.size());
         chk("m_overflow", int'(overflow), int'(m_ovf));
         chk("m_drop_cnt", int'(drop_cnt), m_drop);
      end
   end

   typedef struct {
      bit            strobe;
      bit            ready;
      bit            exp_valid;
      logic [OW-1:0] exp_dout;
      int            exp_level;
   } vec_t;

   vec_t         tbl[19];
   logic [L-1:0] blk[6];
   logic [OW-1:0] words[$];
   int           run;
   int           max_run;

   task automatic do_reset();
      @(posedge clk);
      #1 reset_n = 1'b0; qstrobe = 1'b0; dready = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic drain(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1 qstrobe = 1'b0; dready = 1'b1;
      end
   endtask

   function automatic logic [L-1:0] rnd_blk();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      for (int i = 0; i < 19; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, '0, 0};
      tbl[0].strobe    = 1'b1;
      tbl[1].exp_level = 1;
      for (int k = 0; k < NW; k++) begin
         tbl[k+2].exp_valid = 1'b1;
         tbl[k+2].exp_dout  = OW'(k);
      end

      // Reset values
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("rst_dout", int'(dout), 0);
      chk("rst_dvalid", int'(dvalid), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_drop_cnt", int'(drop_cnt), 0);

      // Single block from the vector table
      q = SINGLE;
      for (int i = 0; i < 19; i++) begin
         @(posedge clk);
         #1 qstrobe = tbl[i].strobe; dready = tbl[i].ready;
         @(negedge clk);
         chk($sformatf("vec%0d_dvalid", i), int'(dvalid), int'(tbl[i].exp_valid));
         if (tbl[i].exp_valid)
            chk($sformatf("vec%0d_dout", i), int'(dout), int'(tbl[i].exp_dout));
         chk($sformatf("vec%0d_level", i), int'(level), tbl[i].exp_level);
      end

      // Backpressure with dready 1,0,0,1,...
      words.delete();
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         #1 qstrobe = (c == 0); q = SINGLE;
         dready = (c % 4 == 0) || (c % 4 == 3);
         @(negedge clk);
         if (dvalid && dready) words.push_back(dout);
      end
      chk("bp_count", words.size(), NW);
      for (int k = 0; k < words.size() && k < NW; k++)
         chk($sformatf("bp_word%0d", k), int'(words[k]), k);

      // Back-to-back blocks, strobes 3 cycles apart
      run = 0;
      max_run = 0;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk);
         #1 qstrobe = (c == 0 || c == 3); q = rnd_blk(); dready = 1'b1;
         @(negedge clk);
         run = dvalid ? run + 1 : 0;
         if (run > max_run) max_run = run;
      end
      chk("b2b_run", max_run, 2 * NW);

      // Overflow: six strobes with the consumer stalled
      do_reset();
      for (int i = 0; i < 6; i++) begin
         blk[i] = rnd_blk();
         @(posedge clk);
         #1 qstrobe = 1'b1; q = blk[i]; dready = 1'b0;
      end
      @(posedge clk);
      #1 qstrobe = 1'b0;
      @(negedge clk);
      chk("ovf_level", int'(level), DEPTH);
      chk("ovf_flag", int'(overflow), 1);
      chk("ovf_drop_cnt", int'(drop_cnt), 1);
      chk("ovf_dvalid", int'(dvalid), 1);
      words.delete();
      for (int c = 0; c < 120; c++) begin
         @(posedge clk);
         #1 dready = 1'b1;
         @(negedge clk);
         if (dvalid && dready) words.push_back(dout);
      end
      chk("ovf_words", words.size(), 5 * NW);
      for (int j = 0; j < words.size() && j < 5 * NW; j++)
         chk($sformatf("ovf_word%0d", j), int'(words[j]),
             int'(blk[j/NW][(j%NW)*OW +: OW]));

      // Reset at word 5 with two blocks queued
      for (int i = 0; i < 3; i++) begin
         blk[i] = rnd_blk();
         @(posedge clk);
         #1 qstrobe = 1'b1; q = blk[i]; dready = 1'b0;
      end
      @(posedge clk);
      #1 qstrobe = 1'b0; dready = 1'b1;
      @(negedge clk);
      chk("mid_level", int'(level), 2);
      repeat (4) @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b0;
      @(negedge clk);
      chk("mid_word5", int'(dout), int'(blk[0][5*OW +: OW]));
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_dvalid", int'(dvalid), 0);
      chk("mid_rst_level", int'(level), 0);
      chk("mid_rst_overflow", int'(overflow), 0);
      chk("mid_rst_drop_cnt", int'(drop_cnt), 0);
      blk[5] = rnd_blk();
      @(posedge clk);
      #1 qstrobe = 1'b1; q = blk[5];
      @(posedge clk);
      #1 qstrobe = 1'b0;
      @(negedge clk);
      chk("mid_t1_dvalid", int'(dvalid), 0);
      @(posedge clk);
      @(negedge clk);
      chk("mid_t2_dvalid", int'(dvalid), 1);
      chk("mid_t2_dout", int'(dout), int'(blk[5][OW-1:0]));
      drain(30);

      // Full FIFO with a simultaneous pop
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1 qstrobe = 1'b1; q = rnd_blk(); dready = 1'b0;
      end
      @(posedge clk);
      #1 qstrobe = 1'b0;
      @(negedge clk);
      chk("full_level_pre", int'(level), DEPTH);
      for (int i = 0; i < NW; i++) begin
         @(posedge clk);
         #1 dready = 1'b1; qstrobe = (i == NW - 1); q = rnd_blk();
      end
      @(negedge clk);
      chk("full_last_dvalid", int'(dvalid), 1);
      @(posedge clk);
      #1 qstrobe = 1'b0;
      @(negedge clk);
      chk("full_level_post", int'(level), DEPTH);
      chk("full_overflow", int'(overflow), 0);
      drain(120);

      // Randomized traffic, alternating light and heavy backpressure
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1 qstrobe = ($urandom_range(0, 99) < 30);
         q = rnd_blk();
         dready = ($urandom_range(0, 99) < (((c / 500) % 2 == 0) ? 80 : 15));
      end
      drain(200);
      @(negedge clk);
      chk("end_dvalid", int'(dvalid), 0);
      chk("end_level", int'(level), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
